// File: rtl/gpu_loader.sv
// Program loader and run controller for the GPU core: streams instruction/data
// words into core RAM, then resets, runs and times the core until it halts.
`timescale 1ns/1ps
module gpu_loader #(
    parameter int          ADDRESS_WIDTH  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 32'h00FF_FFFF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_data,
    output logic                     core_reset_n,
    output logic                     core_run,
    input  logic                     core_halted,
    output logic [ADDRESS_WIDTH-1:0] ext_write_address,
    output logic [31:0]              ext_write_data,
    output logic                     ext_enable_write_inst,
    output logic                     ext_enable_write_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [31:0]              cycle_count,
    output logic [2:0]               dbg_state
);

    // Handshake: a word transfers on a rising edge where in_valid && in_ready.
    typedef enum logic [2:0] {
        S_HEADER     = 3'd0,
        S_LOAD       = 3'd1,
        S_CORE_RESET = 3'd2,
        S_RUN        = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     is_data_q, is_data_d;
    logic [13:0]              remain_q, remain_d;
    logic                     rst_cnt_q, rst_cnt_d;
    logic [31:0]              run_cnt_q, run_cnt_d;
    logic [31:0]              cycle_count_q, cycle_count_d;
    logic                     error_q, error_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]              wr_data_q, wr_data_d;
    logic                     wr_inst_q, wr_inst_d;
    logic                     wr_den_q, wr_den_d;
    logic                     core_reset_n_q, core_reset_n_d;
    logic                     accept;
    logic [31:0]              run_next;

    assign accept   = in_valid && in_ready;
    assign run_next = run_cnt_q + 32'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_HEADER;
            addr_q         <= '0;
            is_data_q      <= 1'b0;
            remain_q       <= '0;
            rst_cnt_q      <= 1'b0;
            run_cnt_q      <= '0;
            cycle_count_q  <= '0;
            error_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            wr_inst_q      <= 1'b0;
            wr_den_q       <= 1'b0;
            core_reset_n_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            is_data_q      <= is_data_d;
            remain_q       <= remain_d;
            rst_cnt_q      <= rst_cnt_d;
            run_cnt_q      <= run_cnt_d;
            cycle_count_q  <= cycle_count_d;
            error_q        <= error_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            wr_inst_q      <= wr_inst_d;
            wr_den_q       <= wr_den_d;
            core_reset_n_q <= core_reset_n_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        is_data_d     = is_data_q;
        remain_d      = remain_q;
        rst_cnt_d     = rst_cnt_q;
        run_cnt_d     = run_cnt_q;
        cycle_count_d = cycle_count_q;
        error_d       = error_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        wr_inst_d     = 1'b0;
        wr_den_d      = 1'b0;
        case (state_q)
            S_HEADER: begin
                if (accept) begin
                    case (in_data[31:30])
                        2'b00, 2'b01: begin
                            if (in_data[29:16] != 14'd0) begin
                                addr_d    = ADDRESS_WIDTH'(in_data[15:0]);
                                is_data_d = in_data[30];
                                remain_d  = in_data[29:16];
                                state_d   = S_LOAD;
                            end
                        end
                        2'b10: begin
                            rst_cnt_d = 1'b0;
                            run_cnt_d = '0;
                            state_d   = S_CORE_RESET;
                        end
                        default: error_d = 1'b1;
                    endcase
                end
            end
            S_LOAD: begin
                if (accept) begin
                    wr_addr_d = addr_q;
                    wr_data_d = in_data;
                    wr_inst_d = !is_data_q;
                    wr_den_d  = is_data_q;
                    addr_d    = addr_q + ADDRESS_WIDTH'(4);
                    remain_d  = remain_q - 14'd1;
                    if (remain_q == 14'd1) state_d = S_HEADER;
                end
            end
            S_CORE_RESET: begin
                // core_halted is stale here; the core is clearing it.
                run_cnt_d = '0;
                rst_cnt_d = 1'b1;
                if (rst_cnt_q) state_d = S_RUN;
            end
            S_RUN: begin
                run_cnt_d = run_next;
                if (core_halted) begin
                    cycle_count_d = run_next;
                    state_d       = S_DONE;
                end else if (run_next == TIMEOUT_CYCLES) begin
                    error_d       = 1'b1;
                    cycle_count_d = run_next;
                    state_d       = S_DONE;
                end
            end
            S_DONE:  state_d = S_HEADER;
            default: state_d = S_HEADER;
        endcase
        core_reset_n_d = (state_d != S_CORE_RESET);
    end

    always_comb begin
        in_ready = 1'b0;
        core_run = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            S_HEADER: begin
                in_ready = !reset;
                busy     = 1'b0;
            end
            S_LOAD:  in_ready = !reset;
            S_RUN:   core_run = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign core_reset_n          = core_reset_n_q;
    assign ext_write_address     = wr_addr_q;
    assign ext_write_data        = wr_data_q;
    assign ext_enable_write_inst = wr_inst_q;
    assign ext_enable_write_data = wr_den_q;
    assign error                 = error_q;
    assign cycle_count           = cycle_count_q;
    assign dbg_state             = state_q;

endmodule

// File: tb/tb_gpu_loader.sv
// Bench for gpu_loader: random load/run traffic against a queue-based model,
// with a tiny core stand-in that halts after a chosen number of RUN cycles.
`timescale 1ns/1ps
module tb_gpu_loader;

  localparam int TMO = 100;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        core_reset_n;
  logic        core_run;
  logic        core_halted;
  logic [15:0] ext_write_address;
  logic [31:0] ext_write_data;
  logic        ext_enable_write_inst;
  logic        ext_enable_write_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] cycle_count;
  logic [2:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;

  // write entry {is_data, addr, data}; completion entry {error, cycle_count}
  logic [48:0] exp_q[$];
  logic [32:0] exp_done_q[$];
  logic        err_model = 1'b0;

  gpu_loader #(.ADDRESS_WIDTH(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_reset_n(core_reset_n), .core_run(core_run), .core_halted(core_halted),
    .ext_write_address(ext_write_address), .ext_write_data(ext_write_data),
    .ext_enable_write_inst(ext_enable_write_inst),
    .ext_enable_write_data(ext_enable_write_data),
    .busy(busy), .done(done), .error(error), .cycle_count(cycle_count),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- core stand-in ----------------
  logic halt_en = 1'b0;
  int   halt_delay = 1;
  int   run_cycles = 0;

  always @(posedge clock) begin
    if (!core_reset_n) run_cycles <= 0;
    else if (core_run) run_cycles <= run_cycles + 1;
  end

  // Halted becomes visible during the halt_delay-th RUN cycle and stays until core reset.
  assign core_halted = halt_en && core_reset_n && (core_run || run_cycles != 0)
                       && (run_cycles + 1 >= halt_delay);

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    logic [48:0] e;
    logic [48:0] g;
    logic [32:0] ed;
    if (reset === 1'b0) begin
      if (ext_enable_write_inst || ext_enable_write_data) begin
        vectors++;
        g = {ext_enable_write_data, ext_write_address, ext_write_data};
        if (ext_enable_write_inst && ext_enable_write_data) begin
          miscompares++;
          $display("FAIL write_strobes: both enables high at addr %h", ext_write_address);
        end else if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL write_unexpected: got kind/addr/data %h, required no write", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            miscompares++;
            $display("FAIL write_event: got kind/addr/data %h, required %h", g, e);
          end
        end
      end
      if (done) begin
        vectors++;
        if (exp_done_q.size() == 0) begin
          miscompares++;
          $display("FAIL done_unexpected: got error/count %h, required no done", {error, cycle_count});
        end else begin
          ed = exp_done_q.pop_front();
          if ({error, cycle_count} !== ed || core_run !== 1'b0) begin
            miscompares++;
            $display("FAIL done_event: got error/count %h run %b, required %h run 0",
                     {error, cycle_count}, core_run, ed);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d);
    logic rdy;
    logic acc;
    in_valid = 1'b1;
    in_data  = d;
    acc = 1'b0;
    for (int i = 0; i < 1000 && !acc; i++) begin
      rdy = in_ready;
      @(posedge clock);
      acc = rdy;
      #1;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake_timeout: word %h never accepted", d);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_payload(input logic is_data, input logic [15:0] addr, input logic [31:0] d);
    exp_q.push_back({is_data, addr, d});
    send_word(d);
    @(negedge clock);
    check("write_latency", {ext_enable_write_data, ext_enable_write_inst},
          is_data ? 2'b10 : 2'b01);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", in_ready, 0);
    check("rst_core_reset_n", core_reset_n, 0);
    check("rst_core_run", core_run, 0);
    check("rst_enables", {ext_enable_write_inst, ext_enable_write_data}, 0);
    check("rst_ext_write", {ext_write_address, ext_write_data}, 0);
    check("rst_busy_done", {busy, done}, 0);
    check("rst_error", error, 0);
    check("rst_cycle_count", cycle_count, 0);
  endtask

  task automatic do_run(input int d, input logic halts);
    int   exp_cc;
    int   seen;
    logic got_done;
    halt_delay = d;
    halt_en    = halts;
    exp_cc     = halts ? d : TMO;
    if (!halts) err_model = 1'b1;
    exp_done_q.push_back({err_model, 32'(exp_cc)});
    send_word(32'h8000_0000);
    in_valid = 1'b0;
    @(negedge clock);
    check("core_reset_c1", {core_reset_n, core_run, in_ready, busy}, 4'b0001);
    @(negedge clock);
    check("core_reset_c2", {core_reset_n, core_run, in_ready, busy}, 4'b0001);
    @(negedge clock);
    check("run_start", {core_reset_n, core_run, in_ready}, 3'b110);
    seen = 1;
    got_done = 1'b0;
    for (int i = 0; i < 300 && !got_done; i++) begin
      @(negedge clock);
      if (done) got_done = 1'b1;
      else if (core_run) seen++;
    end
    check("run_done_seen", got_done, 1);
    check("run_cycles_seen", seen, exp_cc);
    @(negedge clock);
    check("after_done", {core_run, busy, done, error}, {3'b000, err_model});
    check("cycle_count_hold", cycle_count, exp_cc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  typ;
    int          n;
    logic [15:0] start;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_values();
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    check("release_core_reset_n", core_reset_n, 1);
    check("release_idle", {in_ready, busy, core_run}, 3'b100);

    // instruction load, back-to-back
    send_word(32'h0003_0000);
    send_payload(1'b0, 16'h0000, 32'h0050_0093);
    send_payload(1'b0, 16'h0004, 32'h0010_0073);
    send_payload(1'b0, 16'h0008, 32'hDEAD_BEEF);
    idle(1);

    // data load with stalls between words
    send_word(32'h4002_0100);
    idle(3);
    send_payload(1'b1, 16'h0100, $urandom);
    idle(3);
    send_payload(1'b1, 16'h0104, $urandom);
    idle(3);

    // address wrap
    send_word(32'h0002_FFFC);
    send_payload(1'b0, 16'hFFFC, $urandom);
    send_payload(1'b0, 16'h0000, $urandom);
    idle(1);

    // zero-length load
    send_word(32'h0000_1234);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("n0_idle", {in_ready, busy}, 2'b10);
    end
    idle(1);

    // randomized loads
    for (int t = 0; t < 8; t++) begin
      typ   = 2'($urandom_range(0, 1));
      n     = $urandom_range(1, 6);
      start = 16'($urandom) & 16'hFFFC;
      send_word({typ, 14'(n), start});
      for (int i = 0; i < n; i++) begin
        send_payload(typ[0], 16'((int'(start) + 4 * i) % 65536), $urandom);
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle($urandom_range(0, 2));
    end

    // runs that halt
    do_run(1, 1'b1);
    for (int t = 0; t < 3; t++) do_run($urandom_range(2, 60), 1'b1);

    // reset in the middle of a load
    send_word(32'h0003_0040);
    send_payload(1'b0, 16'h0040, $urandom);
    idle(1);
    check("midload_busy", busy, 1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_reset_values();
    @(posedge clock);
    #1 reset = 1'b0;
    err_model = 1'b0;
    exp_q.delete();
    @(posedge clock);
    #1;
    send_word(32'h4001_0200);
    send_payload(1'b1, 16'h0200, $urandom);
    idle(1);

    // reserved header type
    send_word(32'hC000_0000);
    in_valid = 1'b0;
    err_model = 1'b1;
    @(negedge clock);
    check("reserved_error", {error, in_ready, busy}, 3'b110);
    idle(1);

    // timeout
    do_run(1, 1'b0);

    idle(3);
    check("wr_queue_drained", exp_q.size(), 0);
    check("done_queue_drained", exp_done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/gpu_loader.md
# gpu_loader

Host-side program loader and run controller that sits directly upstream of the GPU core (`Main`). It accepts a 32-bit command/payload word stream over a valid/ready handshake, writes instruction and data words into the core through its external write port while `run` is low, then resets and starts the core, waits for `halted`, and reports completion with an execution cycle count. It is the only block that drives the core's `reset_n`, `run` and `ext_*` write inputs.

## Interface

- `ADDRESS_WIDTH`, 16: byte-address width of the core's external write port.
- `TIMEOUT_CYCLES`, 24'hFFFFFF: maximum run cycles before the run is aborted.
- `clock`  in  1  single clock. One clock; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  stream word valid.
- `in_ready`  out  1  loader can accept a word.
- `in_data`  in  32  stream word.
- `core_reset_n`  out  1  to core `reset_n`.
- `core_run`  out  1  to core `run`.
- `core_halted`  in  1  from core `halted`.
- `ext_write_address`  out  ADDRESS_WIDTH  byte address to core.
- `ext_write_data`  out  32  write data to core.
- `ext_enable_write_inst`  out  1  instruction RAM write strobe.
- `ext_enable_write_data`  out  1  data RAM write strobe.
- `busy`  out  1  high in any state other than HEADER.
- `done`  out  1  one-cycle pulse on run completion.
- `error`  out  1  sticky error flag, cleared only by `reset`.
- `cycle_count`  out  32  cycles of the last completed run.

## Operation

- Header word fields: `[31:30]` type (00 inst load, 01 data load, 10 run, 11 reserved), `[29:16]` word count N (14 bits), `[15:0]` start byte address.
- States:
  - HEADER: `in_ready`=1. On handshake, decode the header.
    - Type 00/01 with N>0: latch address, type and N; go to LOAD.
    - N==0: stay in HEADER, no writes.
    - Type 10: go to CORE_RESET; N and the address are ignored.
    - Type 11: set `error`, stay in HEADER.
  - LOAD: `in_ready`=1. Each accepted word produces one write.
    - Address increments by 4, wrapping modulo 2^ADDRESS_WIDTH.
    - After the Nth word, return to HEADER.
  - CORE_RESET: `in_ready`=0, `core_reset_n`=0, `core_run`=0 for exactly 2 cycles. Clear the run counter. Go to RUN.
  - RUN: `in_ready`=0, `core_run`=1, counter increments every RUN cycle.
    - On `core_halted`=1: latch `cycle_count` = counter value, go to DONE.
    - If the counter reaches TIMEOUT_CYCLES: set `error`, latch `cycle_count`, go to DONE without a halt.
  - DONE: `done`=1 for one cycle, `core_run`=0. Go to HEADER.
- `core_run` is 0 in every state except RUN, so external writes are legal whenever the core is not running.
- Unknown state encoding returns to HEADER.

## Timing

- Reset values, held while `reset`=1:
  - 0: `in_ready`, `core_reset_n`, `core_run`, `ext_enable_write_*`, `ext_write_*`, `busy`, `done`, `error`, `cycle_count`.
  - State = HEADER.
  - `core_reset_n` goes to 1 on the first cycle after reset is released.
- Handshake: a transfer occurs on a clock edge where `in_valid` && `in_ready`. Stalls on `in_valid`=0 are allowed anywhere in LOAD, with no write issued.
- Write latency: the payload word accepted at edge k appears on `ext_write_address/data` with exactly one enable high during cycle k+1. Enables are single-cycle strobes, giving at most one write per cycle. Back-to-back words produce back-to-back strobes.
- The run command is accepted at edge k. CORE_RESET occupies cycles k+1 and k+2, and RUN starts at k+3.
  - `core_halted` is ignored during CORE_RESET, because the core clears it there.
  - `cycle_count` = number of RUN cycles up to and including the cycle `core_halted` is first sampled high.
- `done` is asserted on the cycle after `core_halted` is sampled high; `cycle_count` is valid the same cycle and holds until the next run completes.
- `reset` asserted mid-LOAD or mid-RUN aborts immediately. The core is held in reset the next cycle, and partially loaded words remain in core RAM.
- Address wrap: with start 16'hFFFC and N=2, writes go to FFFC then 0000.

## Test plan

- Inst load: header 0x0003_0000 plus words A, B, C with `in_valid` always high. Required: three consecutive `ext_enable_write_inst` strobes at addresses 0, 4, 8 with data A, B, C, and no data strobes.
- Data load with stalls: header 0x4002_0100, words separated by 3 idle cycles. Required: `ext_enable_write_data` strobes only after each accepted word, at addresses 0x100 and 0x104.
- Run: after loading `addi x1,x0,5; ebreak`, send header 0x8000_0000. Required:
  - `core_reset_n` low for 2 cycles, then `core_run` high.
  - A `done` pulse once `core_halted` is seen, with `cycle_count` equal to the RUN cycles counted by the bench model.
  - `error`=0.
- Timeout: TIMEOUT_CYCLES=100, a program that loops forever, then a run command. Required: `done` after 100 RUN cycles, `error`=1, `cycle_count`=100, `core_run` back to 0.
- Boundaries:
  - Header 0x0000_1234 (N=0): no writes, `in_ready` stays high.
  - Header 0xC000_0000: `error`=1.
  - Header 0x0002_FFFC: writes at FFFC then 0000.
- Reset mid-LOAD: assert `reset` after 1 of 3 words. Required: all outputs return to reset values. The next word is treated as a header.
